// File: rtl/fetch_ctrl.sv
// Purpose: RV32 instruction-fetch sequencer. Owns the PC and keeps one imem transaction in flight.
// Latency: request at T, response at T+1, instruction to decode at T+2. Next request at T+3.
// Backpressure: the request is held with a stable address until imem_req_ready; the instruction is held until inst_ready.
module fetch_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rstl,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fault,
   output logic [XLEN-1:0] fault_pc,
   output logic [31:0]     fetch_count
);

   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2, S_FAULT = 2'd3} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_in_rst;      // set while rstl is sampled low; keeps the request invisible during reset
   logic            r_kill;        // the outstanding response belongs to a redirected-away path
   logic            w_kill_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] r_addr;        // address on the bus; frozen while a request is presented
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_inst_pc;
   logic            r_fault;
   logic [XLEN-1:0] r_fault_pc;
   logic [31:0]     r_fetch_count;

   logic            w_misal;
   logic            w_req_fire;
   logic            w_rsp_good;
   logic            w_take;

   assign w_misal    = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign w_req_fire = imem_req_valid && imem_req_ready;
   // A response is only useful if it was not killed and is not being redirected away this cycle.
   assign w_rsp_good = (r_state == S_WAIT) && imem_rsp_valid && !r_kill && !redirect_valid;
   // A decode handshake coinciding with a redirect does not count.
   assign w_take     = (r_state == S_HOLD) && inst_ready && !redirect_valid;

   assign w_pc_nxt = redirect_valid ? redirect_pc
                   : w_take         ? r_pc + XLEN'(4)
                   :                  r_pc;

   // State and kill flag register.
   always_ff @(posedge clk) begin
      if (!rstl) begin
         r_state  <= S_REQ;
         r_kill   <= 1'b0;
         r_in_rst <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_kill   <= w_kill_nxt;
         r_in_rst <= 1'b0;
      end
   end

   // Next-state and kill decisions; a misaligned redirect overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_kill_nxt  = r_kill;
      case (r_state)
         S_REQ: begin
            if (w_req_fire)
               w_state_nxt = S_WAIT;
            // Only a request already on the bus is stale; otherwise the new address goes out directly.
            if (redirect_valid && imem_req_valid)
               w_kill_nxt = 1'b1;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_kill_nxt = 1'b0;
               if (r_kill || redirect_valid)
                  w_state_nxt = S_REQ;
               else if (imem_rsp_err)
                  w_state_nxt = S_FAULT;
               else
                  w_state_nxt = S_HOLD;
            end else if (redirect_valid) begin
               w_kill_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || inst_ready)
               w_state_nxt = S_REQ;
         end
         S_FAULT: begin
            if (redirect_valid)
               w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
      if (w_misal) begin
         w_state_nxt = S_FAULT;
         w_kill_nxt  = 1'b0;
      end
   end

   // Handshake outputs decoded from registered state only.
   always_comb begin
      imem_req_valid = (r_state == S_REQ) && !r_in_rst;
      inst_valid     = (r_state == S_HOLD);
   end

   // PC, bus address, instruction holding, fault and delivery counter.
   always_ff @(posedge clk) begin
      if (!rstl) begin
         r_pc          <= RESET_PC;
         r_addr        <= RESET_PC;
         r_inst        <= '0;
         r_inst_pc     <= '0;
         r_fault       <= 1'b0;
         r_fault_pc    <= '0;
         r_fetch_count <= '0;
      end else begin
         r_pc <= w_pc_nxt;
         if (!imem_req_valid)
            r_addr <= w_pc_nxt;
         if (w_rsp_good && !imem_rsp_err) begin
            r_inst    <= imem_rsp_data;
            r_inst_pc <= r_pc;
         end
         if (w_take)
            r_fetch_count <= r_fetch_count + 32'd1;
         if (w_misal) begin
            r_fault    <= 1'b1;
            r_fault_pc <= redirect_pc;
         end else if (w_rsp_good && imem_rsp_err) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
         end else if ((r_state == S_FAULT) && redirect_valid) begin
            r_fault    <= 1'b0;
         end
      end
   end

   assign imem_req_addr = r_addr;
   assign inst          = r_inst;
   assign inst_pc       = r_inst_pc;
   assign fault         = r_fault;
   assign fault_pc      = r_fault_pc;
   assign fetch_count   = r_fetch_count;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch path of the RV32 core. It owns the architectural PC register and runs one outstanding instruction-memory transaction at a time. It presents fetched instructions to decode over a valid/ready handshake. It accepts redirects (taken branch/jump target from the next-PC logic, or a trap vector) and flushes or discards in-flight fetches accordingly.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rstl  in  1  reset, synchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid (single-cycle pulse)
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  instruction word
inst_pc  out  XLEN  PC of inst
redirect_valid  in  1  load new PC and flush
redirect_pc  in  XLEN  redirect target
fault  out  1  fetch fault pending (sticky)
fault_pc  out  XLEN  faulting address
fetch_count  out  32  instructions delivered to decode, wraps at 2^32

Behaviour:
- Registers: pc, state, kill flag, and inst/inst_pc/fault_pc/fetch_count holding registers. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Reset (rstl=0 at clk edge): pc=RESET_PC, state=S_REQ, kill=0, inst=0, inst_pc=0, fault=0, fault_pc=0, fetch_count=0. While in reset, imem_req_valid=0 and inst_valid=0.
- Reset mid-transaction: the transaction is abandoned. A response arriving in S_REQ is ignored.
- States:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. The address is held stable until imem_req_ready. On ready, go to S_WAIT.
  - S_WAIT: wait for imem_rsp_valid.
    - If kill=1, or redirect_valid is high in the same cycle: discard the response, clear kill, go to S_REQ.
    - Else if imem_rsp_err: fault=1, fault_pc=pc, go to S_FAULT.
    - Else: inst=imem_rsp_data, inst_pc=pc, go to S_HOLD.
  - S_HOLD: inst_valid=1. On inst_ready without redirect: pc=pc+4 (mod 2^XLEN), fetch_count+1, go to S_REQ.
  - S_FAULT: imem_req_valid=0, inst_valid=0. Remains here until a redirect.
- Redirect handling, per state:
  - Any state: redirect sets pc=redirect_pc.
  - S_REQ, request not accepted: the request continues with the old address (stability rule), kill=1.
  - S_REQ, request accepted in the same cycle: go to S_WAIT with kill=1.
  - S_WAIT: kill=1 unless the response arrives the same cycle, in which case it is discarded and the state goes to S_REQ.
  - S_HOLD: the held instruction is dropped (inst_valid low next cycle) and the state goes to S_REQ. If inst_ready is high in the same cycle, the handshake does not count: no fetch_count increment, and decode flushes on redirect_valid.
  - S_FAULT: fault clears and the state goes to S_REQ.
- Misaligned redirect (redirect_pc[1:0]!=0): fault=1, fault_pc=redirect_pc, go to S_FAULT. No request is issued.
- Latency, with memory always ready and a 1-cycle response:
  - req at T, rsp at T+1, inst_valid at T+2.
  - With decode always ready, the next req is at T+3, giving a throughput of 1 instruction per 3 cycles.
- imem_rsp_valid outside S_WAIT is ignored.

Test Plan:
- Reset release, RESET_PC=0, memory always ready, rsp next cycle with data 0x00000013 ×3 -> req addrs 0x0, 0x4, 0x8. inst_valid every 3rd cycle. inst_pc 0x0/0x4/0x8. fetch_count=3.
- imem_req_ready held low 4 cycles -> imem_req_valid=1 and addr stable 0x0 throughout. Accepted on cycle 5, WAIT follows.
- Redirect to 0x100 while in S_WAIT, response arrives 2 cycles later -> response discarded, inst_valid stays 0. Next req addr=0x100.
- Redirect 0x200 in S_HOLD with inst_ready=1 the same cycle -> fetch_count unchanged, inst_valid low next cycle, next req addr=0x200.
- imem_rsp_err on fetch of 0x8 -> fault=1, fault_pc=0x8, no further req. Redirect 0x80 -> fault=0, req addr 0x80. Redirect 0x82 -> fault=1, fault_pc=0x82, no req.
- rstl low during S_WAIT, response arrives during reset and the cycle after -> ignored. First req after release is to RESET_PC, fetch_count=0.
